// File: rtl/fpu_scoreboard_pkg.sv
// Shared FP scoreboard types and default pipeline latencies.
// Package name: definitions.
package definitions;

  localparam int FPU_NUM_FREGS   = 32;
  localparam int FPU_PIPE_DEPTH  = 3;
  localparam int FPU_DIV_LATENCY = 8;
  localparam int FREG_AW = $clog2(FPU_NUM_FREGS);

  typedef logic [FREG_AW-1:0] FRegAddr;

  typedef struct packed {
    FRegAddr fs;
    FRegAddr ft;
    FRegAddr fd;
    logic    fs_used;
    logic    ft_used;
    logic    fd_wr;
    logic    div;
  } FPU_issue;

  typedef struct packed {
    logic    issue_ok;
    logic    stall;
    logic    div_busy;
    logic    wb_valid;
    FRegAddr wb_fd;
  } FPU_sb_out;

endpackage

// File: rtl/wb_slot_ring.sv
// Writeback reservation ring: slots DEPTH..1 shift toward slot 1,
// which retires onto the single FP writeback port.
module wb_slot_ring #(
  parameter int DEPTH = 8,
  parameter int AW    = 5,
  parameter int SW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          reserve,
  input  logic [SW-1:0] res_slot,
  input  logic [AW-1:0] res_fd,
  output logic          res_busy,
  output logic          ret_valid,
  output logic [AW-1:0] ret_fd
);

  logic [DEPTH:1] v_q;
  logic [DEPTH:1] v_sh;
  logic [AW-1:0]  fd_q  [DEPTH:1];
  logic [AW-1:0]  fd_sh [DEPTH:1];

  // Occupancy is judged post-shift, where a new reservation would land.
  always_comb begin
    v_sh     = '0;
    res_busy = 1'b0;
    for (int i = 1; i <= DEPTH; i++) fd_sh[i] = '0;
    for (int i = 1; i < DEPTH; i++) begin
      v_sh[i]  = v_q[i+1];
      fd_sh[i] = fd_q[i+1];
    end
    for (int i = 1; i <= DEPTH; i++)
      if (res_slot == SW'(i)) res_busy = v_sh[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 1; i <= DEPTH; i++) fd_q[i] <= '0;
    end else begin
      for (int i = 1; i <= DEPTH; i++) begin
        if (reserve && res_slot == SW'(i)) begin
          v_q[i]  <= 1'b1;
          fd_q[i] <= res_fd;
        end else begin
          v_q[i]  <= v_sh[i];
          fd_q[i] <= fd_sh[i];
        end
      end
    end
  end

  assign ret_valid = v_q[1];
  assign ret_fd    = v_q[1] ? fd_q[1] : '0;

endmodule

// File: rtl/fpu_scoreboard.sv
// In-order FP issue scoreboard with writeback-port and divider arbitration.
// FPU_WB_BYPASS_EN: treat the register retiring this cycle as not pending.
module fpu_scoreboard
  import definitions::*;
#(
  parameter int NUM_FREGS   = FPU_NUM_FREGS,
  parameter int PIPE_DEPTH  = FPU_PIPE_DEPTH,
  parameter int DIV_LATENCY = FPU_DIV_LATENCY
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic                 flush,
  input  logic [4:0]           issue_fs,
  input  logic [4:0]           issue_ft,
  input  logic                 issue_fs_used,
  input  logic                 issue_ft_used,
  input  logic [4:0]           issue_fd,
  input  logic                 issue_fd_wr,
  input  logic                 issue_div,
  output logic                 issue_ok,
  output logic                 stall,
  output logic [NUM_FREGS-1:0] pending_vec,
  output logic                 div_busy,
  output logic                 wb_valid,
  output logic [4:0]           wb_fd
);

  localparam int SW = 4;

  FPU_issue  iss;
  FPU_sb_out sb;

  logic [NUM_FREGS-1:0] pending_q;
  logic [NUM_FREGS-1:0] pend_eff;
  logic [NUM_FREGS-1:0] ret_mask;
  logic [NUM_FREGS-1:0] set_mask;
  logic [SW-1:0]        lat;
  logic [SW-1:0]        cnt_q;
  logic                 slot_busy;
  logic                 ret_valid;
  FRegAddr              ret_fd;
  logic                 raw;
  logic                 waw;
  logic                 port;
  logic                 divh;
  logic                 ok;

  assign iss = '{
    fs:      issue_fs,
    ft:      issue_ft,
    fd:      issue_fd,
    fs_used: issue_fs_used,
    ft_used: issue_ft_used,
    fd_wr:   issue_fd_wr,
    div:     issue_div
  };

  assign lat = iss.div ? SW'(DIV_LATENCY) : SW'(PIPE_DEPTH);

  wb_slot_ring #(
    .DEPTH(DIV_LATENCY),
    .AW   ($bits(FRegAddr)),
    .SW   (SW)
  ) u_ring (
    .clk      (clk),
    .rst      (rst),
    .reserve  (ok & iss.fd_wr),
    .res_slot (lat),
    .res_fd   (iss.fd),
    .res_busy (slot_busy),
    .ret_valid(ret_valid),
    .ret_fd   (ret_fd)
  );

  always_comb begin
    ret_mask = '0;
    if (ret_valid) ret_mask[ret_fd] = 1'b1;
  end

`ifdef FPU_WB_BYPASS_EN
  assign pend_eff = pending_q & ~ret_mask;
`else
  assign pend_eff = pending_q;
`endif

  assign raw  = (iss.fs_used & pend_eff[iss.fs]) |
                (iss.ft_used & pend_eff[iss.ft]);
  assign waw  = iss.fd_wr & pend_eff[iss.fd];
  assign port = iss.fd_wr & slot_busy;
  assign divh = iss.div & sb.div_busy;
  assign ok   = issue_valid & ~flush &
                ~(raw | waw | port | divh);

  always_comb begin
    set_mask = '0;
    if (ok && iss.fd_wr) set_mask[iss.fd] = 1'b1;
  end

  // Clear first, then set, so a same-cycle re-issue keeps its bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= (pending_q & ~ret_mask) | set_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt_q <= '0;
    else if (ok && iss.div) cnt_q <= SW'(DIV_LATENCY);
    else if (cnt_q != '0)   cnt_q <= cnt_q - SW'(1);
  end

  assign sb.issue_ok = ok;
  assign sb.stall    = issue_valid & ~flush & ~ok;
  assign sb.div_busy = (cnt_q != '0);
  assign sb.wb_valid = ret_valid;
  assign sb.wb_fd    = ret_fd;

  assign issue_ok    = sb.issue_ok;
  assign stall       = sb.stall;
  assign div_busy    = sb.div_busy;
  assign wb_valid    = sb.wb_valid;
  assign wb_fd       = sb.wb_fd;
  assign pending_vec = pending_q;

endmodule

// File: tb/tb_fpu_scoreboard.sv
// Scoreboard bench for fpu_scoreboard: directed issue sequences,
// expected writebacks queued at issue and checked by a monitor.
module tb_fpu_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  issue_fs = '0;
  logic [4:0]  issue_ft = '0;
  logic        issue_fs_used = 1'b0;
  logic        issue_ft_used = 1'b0;
  logic [4:0]  issue_fd = '0;
  logic        issue_fd_wr = 1'b0;
  logic        issue_div = 1'b0;
  logic        issue_ok;
  logic        stall;
  logic [31:0] pending_vec;
  logic        div_busy;
  logic        wb_valid;
  logic [4:0]  wb_fd;

  typedef struct {
    int         cyc;
    logic [4:0] fd;
  } wb_exp_t;

  wb_exp_t wb_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

`ifdef FPU_WB_BYPASS_EN
  localparam int DEP_CYC = 3;
`else
  localparam int DEP_CYC = 4;
`endif

  fpu_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .flush        (flush),
    .issue_fs     (issue_fs),
    .issue_ft     (issue_ft),
    .issue_fs_used(issue_fs_used),
    .issue_ft_used(issue_ft_used),
    .issue_fd     (issue_fd),
    .issue_fd_wr  (issue_fd_wr),
    .issue_div    (issue_div),
    .issue_ok     (issue_ok),
    .stall        (stall),
    .pending_vec  (pending_vec),
    .div_busy     (div_busy),
    .wb_valid     (wb_valid),
    .wb_fd        (wb_fd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Writeback monitor: every retire must match the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_valid) begin
        n_cmp++;
        if (wb_q.size() == 0) begin
          n_err++;
          $display("FAIL wb_unexpected: got fd=%0d expected none (cycle %0d)",
                   wb_fd, cyc);
        end else begin
          wb_exp_t e;
          e = wb_q.pop_front();
          if (e.cyc != cyc || e.fd != wb_fd) begin
            n_err++;
            $display("FAIL wb_match: got fd=%0d at %0d expected fd=%0d at %0d",
                     wb_fd, cyc, e.fd, e.cyc);
          end
        end
      end else if (wb_q.size() > 0 && wb_q[0].cyc <= cyc) begin
        wb_exp_t e;
        e = wb_q.pop_front();
        n_cmp++;
        n_err++;
        $display("FAIL wb_missing: got none expected fd=%0d at %0d",
                 e.fd, e.cyc);
      end else if (wb_fd != 5'd0) begin
        n_cmp++;
        n_err++;
        $display("FAIL wb_fd_idle: got %0d expected 0", wb_fd);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic fl,
                        input logic [4:0] fs, input logic fsu,
                        input logic [4:0] fd, input logic fdw,
                        input logic dv);
    issue_valid   = v;
    flush         = fl;
    issue_fs      = fs;
    issue_fs_used = fsu;
    issue_ft      = 5'd0;
    issue_ft_used = 1'b0;
    issue_fd      = fd;
    issue_fd_wr   = fdw;
    issue_div     = dv;
  endtask

  task automatic idle(input int n);
    set_in(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (n) nxt();
  endtask

  task automatic push_wb(input int c, input logic [4:0] fd);
    wb_exp_t e;
    e.cyc = c;
    e.fd  = fd;
    wb_q.push_back(e);
  endtask

  initial begin
    int t0;
    set_in(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pending", pending_vec, 32'h0);
    chk("rst_div_busy", {31'd0, div_busy}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_fd", {27'd0, wb_fd}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    nxt();
    rst = 1'b0;
    idle(1);

    // add fd=4: pending cycles 1..3, retire at 3
    t0 = cyc;
    set_in(1'b1, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    @(negedge clk);
    chk("add_ok", {31'd0, issue_ok}, 32'd1);
    chk("add_stall", {31'd0, stall}, 32'd0);
    push_wb(t0 + 3, 5'd4);
    for (int k = 1; k <= 4; k++) begin
      nxt();
      set_in(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      chk("add_pend", pending_vec, (k <= 3) ? 32'h10 : 32'h0);
    end
    idle(3);

    // RAW: dependent fs=4 held valid until it issues
    t0 = cyc;
    set_in(1'b1, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    @(negedge clk);
    chk("raw_src_ok", {31'd0, issue_ok}, 32'd1);
    push_wb(t0 + 3, 5'd4);
    for (int k = 1; k <= DEP_CYC; k++) begin
      nxt();
      set_in(1'b1, 1'b0, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0);
      @(negedge clk);
      chk("raw_ok", {31'd0, issue_ok}, {31'd0, k == DEP_CYC});
      chk("raw_stall", {31'd0, stall}, {31'd0, k != DEP_CYC});
      if (k == DEP_CYC) push_wb(t0 + DEP_CYC + 3, 5'd5);
    end
    nxt();
    idle(6);

    // divide fd=7 then a second divide held valid
    t0 = cyc;
    set_in(1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    @(negedge clk);
    chk("div_ok", {31'd0, issue_ok}, 32'd1);
    push_wb(t0 + 8, 5'd7);
    for (int k = 1; k <= 9; k++) begin
      nxt();
      set_in(1'b1, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
      @(negedge clk);
      chk("div_busy", {31'd0, div_busy}, {31'd0, k <= 8});
      chk("div2_ok", {31'd0, issue_ok}, {31'd0, k == 9});
      chk("div2_stall", {31'd0, stall}, {31'd0, k < 9});
      if (k == 9) push_wb(t0 + 17, 5'd8);
    end
    nxt();
    idle(12);

    // port conflict: add presented 5 cycles after a divide
    t0 = cyc;
    set_in(1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    @(negedge clk);
    push_wb(t0 + 8, 5'd7);
    nxt();
    idle(4);
    set_in(1'b1, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
    @(negedge clk);
    chk("port_cycle", cyc, t0 + 5);
    chk("port_stall", {31'd0, stall}, 32'd1);
    chk("port_ok0", {31'd0, issue_ok}, 32'd0);
    nxt();
    @(negedge clk);
    chk("port_ok1", {31'd0, issue_ok}, 32'd1);
    push_wb(t0 + 9, 5'd2);
    nxt();
    idle(10);

    // flush: never issues, never stalls, no state change
    set_in(1'b1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    @(negedge clk);
    chk("flush_ok", {31'd0, issue_ok}, 32'd0);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    nxt();
    set_in(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_pend", pending_vec, 32'h0);
    nxt();
    idle(4);

    // reset mid-divide
    t0 = cyc;
    set_in(1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    @(negedge clk);
    push_wb(t0 + 8, 5'd7);
    nxt();
    idle(2);
    @(negedge clk);
    chk("pre_rst_pend", pending_vec, 32'h80);
    chk("pre_rst_busy", {31'd0, div_busy}, 32'd1);
    nxt();
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_pend", pending_vec, 32'h0);
    chk("mid_rst_busy", {31'd0, div_busy}, 32'd0);
    chk("mid_rst_wb", {26'd0, wb_valid, wb_fd}, 32'd0);
    wb_q.delete();
    #1 rst = 1'b0;
    set_in(1'b1, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    @(negedge clk);
    chk("post_rst_div_ok", {31'd0, issue_ok}, 32'd1);
    push_wb(cyc + 8, 5'd9);
    nxt();
    idle(12);

    chk("wb_drain", wb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
